llkid_key_sender: RTL and testbench

- Initiator side of the LLKI discrete key interface.
- Holds a host-written key of KEY_WORDS 64-bit words and, on command, streams it word by word to a mock TSS core's key-receive port over the valid/ready handshake.
- Waits for key-complete, or drives the clear-key/ack exchange.
- Sits between the LLKI protocol processing logic and each locked core's LLKI discrete ports; reports busy, done and error status back to the host.

---
 rtl/llkid_key_sender.sv | 215 +++++++++++++++++++++
 tb/tb_llkid_key_sender.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llkid_key_sender.sv
// ============================================================================
// Module   : llkid_key_sender
// Purpose  : Initiator side of the LLKI discrete key interface. Holds a
//            host-written key of KEY_WORDS 64-bit words and, on command,
//            streams it word by word to a locked core over valid/ready.
//            It then waits for key-complete, or it runs the clear-key/ack
//            exchange instead. Busy, done and error status go to the host.
// Options  : `define LLKID_SENDER_SCRUB_EN -> the key buffer is zeroed after
//            a successful load and on entry to the clear sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module llkid_key_sender #(
    parameter  int KEY_WORDS      = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1,
    localparam int TMO_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    // host key buffer write port
    input  logic             key_wr_en,
    input  logic [IDX_W-1:0] key_wr_idx,
    input  logic [63:0]      key_wr_data,
    // host commands and status
    input  logic             cmd_load,
    input  logic             cmd_clear,
    output logic             busy,
    output logic             done,
    output logic [1:0]       error,
    // LLKI discrete port towards the target core
    output logic [63:0]      llkid_key_data,
    output logic             llkid_key_valid,
    input  logic             llkid_key_ready,
    input  logic             llkid_key_complete,
    output logic             llkid_clear_key,
    input  logic             llkid_clear_key_ack
);

    localparam logic [1:0]       c_ERR_NONE    = 2'd0;
    localparam logic [1:0]       c_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0]       c_ERR_EARLY   = 2'd2;
    localparam logic [IDX_W-1:0] c_LAST_IDX    = IDX_W'(KEY_WORDS - 1);
    localparam logic [TMO_W-1:0] c_TMO_LIMIT   = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_CMP = 2'd2,
        S_CLEAR    = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [TMO_W-1:0] r_tmo;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_error;
    logic [63:0]      r_data;
    logic             r_valid;
    logic             r_clear;
    logic [63:0]      r_buf [KEY_WORDS];

    logic [IDX_W-1:0] w_idx_next;
    logic             w_tmo_hit;
    logic             w_wr_ok;
    logic             w_scrub;

    assign w_idx_next = r_idx + 1'b1;
    assign w_tmo_hit  = (r_tmo == c_TMO_LIMIT);

    // The buffer is locked whenever a command is in flight.
    assign w_wr_ok = key_wr_en && (r_state == S_IDLE) &&
                     ({1'b0, key_wr_idx} < (IDX_W + 1)'(KEY_WORDS));

`ifdef LLKID_SENDER_SCRUB_EN
    // Wipe on the completing edge of a load and on the edge that enters CLEAR.
    assign w_scrub = ((r_state == S_WAIT_CMP) && llkid_key_complete) ||
                     ((r_state == S_IDLE) && cmd_clear);
`else
    assign w_scrub = 1'b0;
`endif

    // Key buffer: host writes while idle, optional scrub after use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_scrub) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_buf[key_wr_idx] <= key_wr_data;
        end
    end

    // Command sequencer with registered interface outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= c_ERR_NONE;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // clear has priority when both commands arrive together
                    if (cmd_clear) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_error <= c_ERR_NONE;
                        r_clear <= 1'b1;
                        r_tmo   <= '0;
                    end else if (cmd_load) begin
                        r_state <= S_SEND;
                        r_busy  <= 1'b1;
                        r_error <= c_ERR_NONE;
                        r_idx   <= '0;
                        r_data  <= r_buf[0];
                        r_valid <= 1'b1;
                        r_tmo   <= '0;
                    end
                end

                S_SEND: begin
                    // valid is always high here, so ready alone is a handshake
                    if (llkid_key_ready) begin
                        r_tmo <= '0;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= S_WAIT_CMP;
                            r_valid <= 1'b0;
                            r_data  <= '0;
                        end else begin
                            r_idx  <= w_idx_next;
                            r_data <= r_buf[w_idx_next];
                        end
                    end else if (llkid_key_complete) begin
                        // target claims completion before it has every word
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_error <= c_ERR_EARLY;
                    end else if (w_tmo_hit) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_error <= c_ERR_TIMEOUT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_WAIT_CMP: begin
                    if (llkid_key_complete) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tmo_hit) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_error <= c_ERR_TIMEOUT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_CLEAR: begin
                    // ack may be a single pulse or a held level
                    if (llkid_clear_key_ack) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_clear <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tmo_hit) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_clear <= 1'b0;
                        r_error <= c_ERR_TIMEOUT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_clear <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign llkid_key_data  = r_data;
    assign llkid_key_valid = r_valid;
    assign llkid_clear_key = r_clear;

endmodule

`default_nettype wire

// File: tb/tb_llkid_key_sender.sv
// ============================================================================
// Module   : tb_llkid_key_sender
// Purpose  : Scoreboard bench for llkid_key_sender. Expected key words and
//            expected done-time error codes are queued when commands are
//            issued; a negedge monitor pops and compares them as the DUT
//            presents handshakes and done pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_llkid_key_sender;

    localparam int KW  = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_wr_en = 1'b0;
    logic [1:0]  key_wr_idx = '0;
    logic [63:0] key_wr_data = '0;
    logic        cmd_load = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  error;
    logic [63:0] llkid_key_data;
    logic        llkid_key_valid;
    logic        llkid_key_ready = 1'b0;
    logic        llkid_key_complete = 1'b0;
    logic        llkid_clear_key;
    logic        llkid_clear_key_ack = 1'b0;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int h0;

    logic [63:0] exp_words [$];
    logic [1:0]  exp_done  [$];
    logic [63:0] img  [KW];
    logic [63:0] set1 [KW];
    logic [63:0] set2 [KW];

    llkid_key_sender #(
        .KEY_WORDS      (KW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .key_wr_en           (key_wr_en),
        .key_wr_idx          (key_wr_idx),
        .key_wr_data         (key_wr_data),
        .cmd_load            (cmd_load),
        .cmd_clear           (cmd_clear),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .llkid_key_data      (llkid_key_data),
        .llkid_key_valid     (llkid_key_valid),
        .llkid_key_ready     (llkid_key_ready),
        .llkid_key_complete  (llkid_key_complete),
        .llkid_clear_key     (llkid_clear_key),
        .llkid_clear_key_ack (llkid_clear_key_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // write one buffer word; 'upd' says whether the model expects it to land
    task automatic wr(input int idx, input logic [63:0] d, input bit upd);
        key_wr_en   = 1'b1;
        key_wr_idx  = idx[1:0];
        key_wr_data = d;
        tick;
        key_wr_en   = 1'b0;
        if (upd) img[idx] = d;
    endtask

    task automatic wr_set(input bit which);
        for (int i = 0; i < KW; i++) wr(i, which ? set2[i] : set1[i], 1'b1);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) exp_words.push_back(img[i]);
    endtask

    task automatic pulse_load;
        cmd_load = 1'b1;
        tick;
        cmd_load = 1'b0;
    endtask

    task automatic scrub_model;
`ifdef LLKID_SENDER_SCRUB_EN
        for (int i = 0; i < KW; i++) img[i] = '0;
`endif
    endtask

    // Monitor: handshakes, data stability, done pulses.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && llkid_key_valid) chk("data hold", llkid_key_data, prev_data);
            if (!llkid_key_valid) chk("data zero when invalid", llkid_key_data, 64'd0);
            if (llkid_key_valid && llkid_key_ready) begin
                hs_cnt++;
                if (exp_words.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected word: got %h expected none", llkid_key_data);
                end else begin
                    chk("key word", llkid_key_data, exp_words.pop_front());
                end
            end
            if (done) begin
                chk("busy at done", busy, 0);
                if (exp_done.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected done: got done=1 error=%0d expected no done", error);
                end else begin
                    chk("error at done", error, exp_done.pop_front());
                end
            end
            prev_hold = llkid_key_valid && !llkid_key_ready;
            prev_data = llkid_key_data;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish before 50000");
        $fatal(1);
    end

    initial begin
        set1[0] = 64'h1111_1111_1111_1111; set1[1] = 64'h2222_2222_2222_2222;
        set1[2] = 64'h3333_3333_3333_3333; set1[3] = 64'h4444_4444_4444_4444;
        set2[0] = 64'hA5A5_0000_0000_0001; set2[1] = 64'h5A5A_0000_0000_0002;
        set2[2] = 64'hDEAD_BEEF_0000_0003; set2[3] = 64'hCAFE_F00D_0000_0004;
        for (int i = 0; i < KW; i++) img[i] = '0;

        // reset state
        tick; tick;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst valid", llkid_key_valid, 0);
        chk("rst data", llkid_key_data, 0);
        chk("rst clear", llkid_clear_key, 0);
        rst_n = 1'b1;
        tick;

        // T1: streaming load, ready held high, complete two cycles later
        wr_set(1'b0);
        llkid_key_ready = 1'b1;
        push_words(KW);
        pulse_load;
        chk("t1 busy", busy, 1);
        chk("t1 valid", llkid_key_valid, 1);
        chk("t1 first word", llkid_key_data, set1[0]);
        h0 = hs_cnt;
        repeat (KW) tick;
        chk("t1 handshakes", hs_cnt - h0, KW);
        chk("t1 valid drop", llkid_key_valid, 0);
        chk("t1 busy wait", busy, 1);
        tick;
        llkid_key_complete = 1'b1;
        exp_done.push_back(2'd0);
        tick;
        chk("t1 done", done, 1);
        chk("t1 busy off", busy, 0);
        chk("t1 error", error, 0);
        llkid_key_complete = 1'b0;
        scrub_model;
        tick;
        chk("t1 done width", done, 0);

        // T2: ready pattern 1,0,0 repeating
        wr_set(1'b1);
        llkid_key_ready = 1'b0;
        push_words(KW);
        pulse_load;
        h0 = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            llkid_key_ready = ((i % 3) == 0);
            tick;
        end
        chk("t2 handshakes", hs_cnt - h0, KW);
        chk("t2 valid drop", llkid_key_valid, 0);
        llkid_key_complete = 1'b1;
        exp_done.push_back(2'd0);
        tick;
        chk("t2 done", done, 1);
        llkid_key_complete = 1'b0;
        scrub_model;
        tick;

        // T3: target never ready -> timeout, then a clean restart
        llkid_key_ready = 1'b0;
        pulse_load;
        repeat (TMO - 1) tick;
        chk("t3 valid before timeout", llkid_key_valid, 1);
        chk("t3 busy before timeout", busy, 1);
        tick;
        chk("t3 valid after timeout", llkid_key_valid, 0);
        chk("t3 error timeout", error, 1);
        chk("t3 busy after timeout", busy, 0);
        chk("t3 no done", done, 0);
        wr_set(1'b0);
        chk("t3 error held", error, 1);
        llkid_key_ready = 1'b1;
        push_words(KW);
        pulse_load;
        chk("t3 error cleared", error, 0);
        chk("t3 restart word0", llkid_key_data, set1[0]);
        repeat (KW - 1) tick;
        llkid_key_complete = 1'b1;      // seen on the final handshake edge
        tick;
        chk("t3 valid drop", llkid_key_valid, 0);
        chk("t3 no early error", error, 0);
        chk("t3 busy wait", busy, 1);
        exp_done.push_back(2'd0);
        tick;
        chk("t3 done", done, 1);
        llkid_key_complete = 1'b0;
        scrub_model;
        tick;

        // T4: early complete after two words, then a clear with delayed ack
        wr_set(1'b1);
        llkid_key_ready = 1'b1;
        push_words(2);
        pulse_load;
        tick; tick;
        llkid_key_ready = 1'b0;
        llkid_key_complete = 1'b1;
        tick;
        chk("t4 error early", error, 2);
        chk("t4 valid drop", llkid_key_valid, 0);
        chk("t4 busy off", busy, 0);
        chk("t4 no done", done, 0);
        llkid_key_complete = 1'b0;
        cmd_clear = 1'b1;
        tick;
        cmd_clear = 1'b0;
        scrub_model;
        chk("t4 clear req", llkid_clear_key, 1);
        chk("t4 clear busy", busy, 1);
        chk("t4 clear error reset", error, 0);
        tick; tick;
        llkid_clear_key_ack = 1'b1;
        exp_done.push_back(2'd0);
        tick;
        chk("t4 clear done", done, 1);
        chk("t4 clear drop", llkid_clear_key, 0);
        llkid_clear_key_ack = 1'b0;
        tick;

        // T5: both commands together -> clear only; load ignored in CLEAR
        cmd_load = 1'b1;
        cmd_clear = 1'b1;
        tick;
        cmd_load = 1'b0;
        cmd_clear = 1'b0;
        scrub_model;
        chk("t5 clear wins", llkid_clear_key, 1);
        chk("t5 no valid", llkid_key_valid, 0);
        pulse_load;
        chk("t5 load ignored valid", llkid_key_valid, 0);
        chk("t5 still clearing", llkid_clear_key, 1);
        llkid_clear_key_ack = 1'b1;
        exp_done.push_back(2'd0);
        tick;
        chk("t5 done", done, 1);
        chk("t5 clear drop", llkid_clear_key, 0);
        tick;
        chk("t5 level ack no repeat", done, 0);
        llkid_clear_key_ack = 1'b0;

        // T6: writes during SEND must not change the transmitted key
        wr_set(1'b0);
        llkid_key_ready = 1'b0;
        push_words(KW);
        pulse_load;
        wr(0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        wr(2, 64'hBAD2_BAD2_BAD2_BAD2, 1'b0);
        chk("t6 word0 held", llkid_key_data, set1[0]);
        h0 = hs_cnt;
        llkid_key_ready = 1'b1;
        repeat (KW) tick;
        chk("t6 handshakes", hs_cnt - h0, KW);
        llkid_key_complete = 1'b1;
        exp_done.push_back(2'd0);
        tick;
        chk("t6 done", done, 1);
        llkid_key_complete = 1'b0;
        scrub_model;
        tick;

        // T6b: reload without rewriting (retained key, or zeros when scrubbed)
        push_words(KW);
        pulse_load;
        repeat (KW) tick;
        llkid_key_complete = 1'b1;
        exp_done.push_back(2'd0);
        tick;
        chk("t6b done", done, 1);
        llkid_key_complete = 1'b0;
        scrub_model;
        tick;

        // T7: asynchronous reset mid-SEND after two words
        wr_set(1'b1);
        llkid_key_ready = 1'b1;
        push_words(2);
        pulse_load;
        tick; tick;
        #1 rst_n = 1'b0;
        #1;
        chk("t7 valid", llkid_key_valid, 0);
        chk("t7 data", llkid_key_data, 0);
        chk("t7 busy", busy, 0);
        chk("t7 clear", llkid_clear_key, 0);
        for (int i = 0; i < KW; i++) img[i] = '0;
        tick;
        rst_n = 1'b1;
        tick;

        // T8: buffer is zero after reset
        push_words(KW);
        pulse_load;
        repeat (KW) tick;
        llkid_key_complete = 1'b1;
        exp_done.push_back(2'd0);
        tick;
        chk("t8 done", done, 1);
        llkid_key_complete = 1'b0;
        llkid_key_ready = 1'b0;
        tick; tick;

        chk("words left", exp_words.size(), 0);
        chk("dones left", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
